// File: rtl/prot_reg_arbiter.sv
// prot_reg_arbiter: round-robin arbiter in front of a permission-checked data register
module prot_reg_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int UIDW = 3,
  parameter logic [2**UIDW-1:0] ALLOW_RST = 8'h10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*UIDW-1:0] req_usr_id,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      deny,
  output logic [DW-1:0]        data_out,
  input  logic                 cfg_we,
  input  logic [2**UIDW-1:0]   cfg_allow,
  input  logic                 cfg_lock,
  output logic [2**UIDW-1:0]   allow_mask,
  output logic                 locked,
  output logic                 busy,
  output logic [7:0]           deny_cnt
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t state, nxt;
  logic [PW-1:0] ptr, win, win_q;
  logic [UIDW-1:0] uid_q;
  logic [DW-1:0] wdata_q;
  logic permitted;
  int cand;
  assign busy = state != IDLE;
  assign permitted = allow_mask[uid_q];
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  // next state: a request in IDLE starts a fixed three-cycle transaction
  always_comb
    nxt = state == IDLE ? (|req ? CHECK : IDLE) : state == CHECK ? RESP : IDLE;
  // round-robin search from ptr; descending scan so the nearest requester wins
  always_comb begin
    win = ptr;
    cand = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NREQ;
      if (req[cand[PW-1:0]]) win = cand[PW-1:0];
    end
  end
  // grant capture, permission decision, response pulses and config registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      win_q <= '0;
      uid_q <= '0;
      wdata_q <= '0;
      ack <= '0;
      deny <= '0;
      data_out <= '0;
      allow_mask <= ALLOW_RST;
      locked <= 1'b0;
      deny_cnt <= '0;
    end else begin
      ack <= '0;
      deny <= '0;
      if (state == IDLE && |req) begin
        win_q <= win;
        uid_q <= req_usr_id[win*UIDW +: UIDW];
        wdata_q <= req_wdata[win*DW +: DW];
        ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
      end
      if (state == CHECK) begin
        if (permitted) begin
          data_out <= wdata_q;
          ack[win_q] <= 1'b1;
        end else begin
          deny[win_q] <= 1'b1;
          deny_cnt <= deny_cnt + 8'(deny_cnt != 8'hFF);
        end
      end
      if (cfg_we && !locked) allow_mask <= cfg_allow;
      if (cfg_lock) locked <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prot_reg_arbiter.sv
// tb_prot_reg_arbiter: table-driven and sequence checks for prot_reg_arbiter
module tb_prot_reg_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [11:0] req_usr_id;
  logic [31:0] req_wdata;
  logic [3:0] ack, deny;
  logic [7:0] data_out;
  logic cfg_we;
  logic [7:0] cfg_allow;
  logic cfg_lock;
  logic [7:0] allow_mask;
  logic locked, busy;
  logic [7:0] deny_cnt;
  int nvec = 0;
  int nerr = 0;

  prot_reg_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_usr_id(req_usr_id), .req_wdata(req_wdata),
    .ack(ack), .deny(deny), .data_out(data_out), .cfg_we(cfg_we), .cfg_allow(cfg_allow),
    .cfg_lock(cfg_lock), .allow_mask(allow_mask), .locked(locked), .busy(busy), .deny_cnt(deny_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rq;
    logic [11:0] uid;
    logic [31:0] wd;
    logic we;
    logic [7:0] alw;
    logic lk;
    logic [3:0] e_ack;
    logic [3:0] e_deny;
    logic [7:0] e_dout;
    logic e_busy;
    logic [7:0] e_mask;
    logic e_lkd;
    logic [7:0] e_dcnt;
  } vec_t;

  vec_t vt[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [11:0] u, input logic [31:0] w,
                       input logic we, input logic [7:0] al, input logic lk);
    req = r;
    req_usr_id = u;
    req_wdata = w;
    cfg_we = we;
    cfg_allow = al;
    cfg_lock = lk;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".ack"}, 32'(ack), 32'd0);
    chk({nm, ".deny"}, 32'(deny), 32'd0);
    chk({nm, ".dout"}, 32'(data_out), 32'd0);
    chk({nm, ".mask"}, 32'(allow_mask), 32'h10);
    chk({nm, ".locked"}, 32'(locked), 32'd0);
    chk({nm, ".dcnt"}, 32'(deny_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nd;
    // single permitted, single denied, cfg during CHECK, lock behaviour
    vt.push_back('{4'b0001, 12'h004, 32'h000000A5, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 8'h10, 1'b0, 8'd0});
    vt.push_back('{4'b0001, 12'h004, 32'h000000A5, 1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 8'hA5, 1'b1, 8'h10, 1'b0, 8'd0});
    vt.push_back('{4'b0001, 12'h004, 32'h000000A5, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 8'h10, 1'b0, 8'd0});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 8'h10, 1'b0, 8'd0});
    vt.push_back('{4'b0010, 12'h010, 32'h00003C00, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b1, 8'h10, 1'b0, 8'd0});
    vt.push_back('{4'b0010, 12'h010, 32'h00003C00, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0010, 8'hA5, 1'b1, 8'h10, 1'b0, 8'd1});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 8'h10, 1'b0, 8'd1});
    vt.push_back('{4'b0100, 12'h100, 32'h00770000, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b1, 8'h10, 1'b0, 8'd1});
    vt.push_back('{4'b0100, 12'h100, 32'h00770000, 1'b1, 8'h00, 1'b0, 4'b0100, 4'b0000, 8'h77, 1'b1, 8'h00, 1'b0, 8'd1});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h77, 1'b0, 8'h00, 1'b0, 8'd1});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b1, 8'h04, 1'b0, 4'b0000, 4'b0000, 8'h77, 1'b0, 8'h04, 1'b0, 8'd1});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h77, 1'b0, 8'h04, 1'b1, 8'd1});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b1, 8'hFF, 1'b0, 4'b0000, 4'b0000, 8'h77, 1'b0, 8'h04, 1'b1, 8'd1});
    vt.push_back('{4'b0001, 12'h002, 32'h00000011, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h77, 1'b1, 8'h04, 1'b1, 8'd1});
    vt.push_back('{4'b0001, 12'h002, 32'h00000011, 1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 8'h11, 1'b1, 8'h04, 1'b1, 8'd1});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h11, 1'b0, 8'h04, 1'b1, 8'd1});
    vt.push_back('{4'b0010, 12'h020, 32'h00002200, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h11, 1'b1, 8'h04, 1'b1, 8'd1});
    vt.push_back('{4'b0010, 12'h020, 32'h00002200, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0010, 8'h11, 1'b1, 8'h04, 1'b1, 8'd2});
    vt.push_back('{4'b0000, 12'h000, 32'h00000000, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h11, 1'b0, 8'h04, 1'b1, 8'd2});

    rst_n = 1'b0;
    drive(4'b0, 12'h0, 32'h0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rq, vt[i].uid, vt[i].wd, vt[i].we, vt[i].alw, vt[i].lk);
      step();
      chk($sformatf("v%0d.ack", i), 32'(ack), 32'(vt[i].e_ack));
      chk($sformatf("v%0d.deny", i), 32'(deny), 32'(vt[i].e_deny));
      chk($sformatf("v%0d.dout", i), 32'(data_out), 32'(vt[i].e_dout));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d.mask", i), 32'(allow_mask), 32'(vt[i].e_mask));
      chk($sformatf("v%0d.locked", i), 32'(locked), 32'(vt[i].e_lkd));
      chk($sformatf("v%0d.dcnt", i), 32'(deny_cnt), 32'(vt[i].e_dcnt));
    end

    // reset clears ptr, mask and lock before the contention run
    drive(4'b0, 12'h0, 32'h0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset("rst2");

    // all four requesters at once: served 0,1,2,3 at cycles 2,5,8,11
    drive(4'b1111, 12'h924, 32'h43424140, 1'b0, 8'h00, 1'b0);
    n = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      chk($sformatf("rr.deny.c%0d", c + 1), 32'(deny), 32'd0);
      if (ack != 4'b0) begin
        chk($sformatf("rr%0d.ack", n), 32'(ack), n < 4 ? 32'(4'b0001 << n) : 32'd0);
        chk($sformatf("rr%0d.cyc", n), c + 1, 2 + 3 * n);
        chk($sformatf("rr%0d.dout", n), 32'(data_out), 32'h40 + n);
        req = req & ~ack;
        n++;
      end
    end
    chk("rr.count", n, 4);
    req = 4'b0001;
    step();
    step();
    chk("rr.after.ack", 32'(ack), 32'b0001);
    req = 4'b0000;
    step();

    // reset while in CHECK aborts; reset also overrides simultaneous cfg writes
    drive(4'b0001, 12'h004, 32'h00000099, 1'b0, 8'h00, 1'b0);
    step();
    chk("mid.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    drive(4'b0000, 12'h0, 32'h0, 1'b1, 8'hFF, 1'b1);
    step();
    chk_reset("mid");
    rst_n = 1'b1;
    drive(4'b0000, 12'h0, 32'h0, 1'b0, 8'h00, 1'b0);
    step();
    chk("mid.late.ack", 32'(ack), 32'd0);
    chk("mid.late.deny", 32'(deny), 32'd0);
    chk("mid.late.dout", 32'(data_out), 32'd0);

    // write and lock in the same cycle
    drive(4'b0000, 12'h0, 32'h0, 1'b1, 8'h30, 1'b1);
    step();
    chk("wl.mask", 32'(allow_mask), 32'h30);
    chk("wl.locked", 32'(locked), 32'd1);
    drive(4'b0000, 12'h0, 32'h0, 1'b0, 8'h00, 1'b0);

    // 260 denials of usr_id 0 saturate deny_cnt at 255
    drive(4'b0001, 12'h000, 32'h000000EE, 1'b0, 8'h00, 1'b0);
    nd = 0;
    for (int c = 0; c < 900 && nd < 260; c++) begin
      step();
      if (deny != 4'b0) begin
        nd++;
        if (nd == 1 || nd == 254 || nd == 255 || nd == 260)
          chk($sformatf("sat.dcnt.%0d", nd), 32'(deny_cnt), nd > 255 ? 32'd255 : 32'(nd));
      end
    end
    chk("sat.denials", nd, 260);
    req = 4'b0000;
    step();
    step();
    step();
    chk("sat.hold", 32'(deny_cnt), 32'd255);
    chk("sat.dout", 32'(data_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
